// File: rtl/ram_bus_pkg.sv
// Shared constants and FSM state encoding for the 32x32 RAM bus master.
package ram_bus_pkg;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int LENW = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_WDRAIN = 2'd2,
        ST_READ   = 2'd3
    } state_t;

endpackage

// File: rtl/rd_fifo2.sv
// Two-entry read-data buffer with occupancy count.
// Latency: pushed word visible at head the cycle after the push edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module rd_fifo2 #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          empty,
    output logic [1:0]    count
);

    logic [DW-1:0] slot0;
    logic [DW-1:0] slot1;
    logic          wptr;
    logic          rptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                if (wptr) slot1 <= push_data;
                else      slot0 <= push_data;
                wptr <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = rptr ? slot1 : slot0;
    assign empty = (count == 2'd0);

endmodule

// File: rtl/ram_bus_master.sv
// Burst initiator for a single-port RAM on a shared bidirectional data bus.
// Latency: write committed 1 cycle after the beat registers; read data valid 2 cycles after issue.
// Backpressure: wr_ready gates beats; reads stall so RAM reads in flight plus buffered words never exceed 2.
module ram_bus_master #(
    parameter int AW   = ram_bus_pkg::AW,
    parameter int DW   = ram_bus_pkg::DW,
    parameter int LENW = ram_bus_pkg::LENW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_wr,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [LENW-1:0] cmd_len,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [DW-1:0]   wr_data,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [DW-1:0]   rd_data,
    output logic            done,
    output logic            ram_ena,
    output logic            ram_wena,
    output logic [AW-1:0]   ram_addr,
    inout  wire  [DW-1:0]   ram_data
);

    import ram_bus_pkg::*;

    state_t          state;
    logic [AW-1:0]   cur_addr;
    logic [LENW-1:0] remain;
    logic            inflight;
    logic [DW-1:0]   wdat;
    logic [1:0]      fcount;
    logic            fempty;
    logic            pop;
    logic            wr_fire;
    logic            issue;
    logic [2:0]      occ;

    assign cmd_ready = (state == ST_IDLE);
    assign wr_ready  = (state == ST_WRITE) && (remain != '0);
    assign wr_fire   = wr_valid && wr_ready;
    assign rd_valid  = !fempty;
    assign pop       = rd_valid && rd_ready;

    // Occupancy after this cycle's pop; a slot is reserved for every read in flight.
    assign occ   = {1'b0, fcount} + {2'b0, inflight} - {2'b0, pop};
    assign issue = (state == ST_READ) && (remain != '0) && (occ < 3'd2);

    // ram_wena is only ever set together with ram_ena, so it doubles as the bus output enable.
    assign ram_data = ram_wena ? wdat : {DW{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cur_addr <= '0;
            remain   <= '0;
            inflight <= 1'b0;
            done     <= 1'b0;
            ram_ena  <= 1'b0;
            ram_wena <= 1'b0;
            ram_addr <= '0;
            wdat     <= '0;
        end else begin
            done     <= 1'b0;
            ram_ena  <= 1'b0;
            ram_wena <= 1'b0;
            inflight <= issue;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cur_addr <= cmd_addr;
                        remain   <= cmd_len;
                        if (cmd_len == '0) done  <= 1'b1;
                        else if (cmd_wr)   state <= ST_WRITE;
                        else               state <= ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (wr_fire) begin
                        ram_ena  <= 1'b1;
                        ram_wena <= 1'b1;
                        ram_addr <= cur_addr;
                        wdat     <= wr_data;
                        cur_addr <= cur_addr + 1'b1;
                        remain   <= remain - 1'b1;
                        if (remain == LENW'(1)) state <= ST_WDRAIN;
                    end
                end
                ST_WDRAIN: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_READ: begin
                    if (issue) begin
                        ram_ena  <= 1'b1;
                        ram_addr <= cur_addr;
                        cur_addr <= cur_addr + 1'b1;
                        remain   <= remain - 1'b1;
                    end
                    if ((remain == '0) && !inflight && (fcount == 2'd1) && pop) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    rd_fifo2 #(.DW(DW)) u_rd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (ram_data),
        .pop       (pop),
        .head      (rd_data),
        .empty     (fempty),
        .count     (fcount)
    );

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed/randomised bench for ram_bus_master with a behavioural RAM and reference memory.
module tb_ram_bus_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [4:0]  cmd_addr;
    logic [5:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        done;
    logic        ram_ena;
    logic        ram_wena;
    logic [4:0]  ram_addr;
    wire  [31:0] ram_data;

    logic [31:0] mem     [32];
    logic [31:0] ref_mem [32];

    int checks = 0;
    int passed = 0;

    ram_bus_master dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .done      (done),
        .ram_ena   (ram_ena),
        .ram_wena  (ram_wena),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data)
    );

    // RAM: synchronous write, combinational read driving the shared bus.
    always @(posedge clk) begin
        if (ram_ena && ram_wena) mem[ram_addr] <= ram_data;
    end
    assign ram_data = (ram_ena && !ram_wena) ? mem[ram_addr] : 32'hzzzz_zzzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_wr_ready"},  wr_ready,  0);
        check({tag, "_rd_valid"},  rd_valid,  0);
        check({tag, "_rd_data"},   rd_data,   0);
        check({tag, "_done"},      done,      0);
        check({tag, "_ram_ena"},   ram_ena,   0);
        check({tag, "_ram_wena"},  ram_wena,  0);
        check({tag, "_ram_addr"},  ram_addr,  0);
    endtask

    task automatic do_write(input logic [4:0] a, input int len, input bit gaps, input string tag);
        int          sent = 0;
        int          cyc  = 0;
        logic [4:0]  ea   = a;
        logic [4:0]  pa   = '0;
        logic [31:0] pd   = '0;
        bit          pf   = 0;
        bit          fire;
        bit          bad_done = 0;
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = a; cmd_len = 6'(len);
        @(negedge clk);
        cmd_valid = 1'b0;
        while (sent < len && cyc < 300) begin
            if (pf) begin
                check({tag, "_pins"}, {ram_ena, ram_wena, ram_addr}, {2'b11, pa});
                check({tag, "_bus"}, ram_data, pd);
            end else begin
                check({tag, "_quiet"}, {ram_ena, ram_wena}, 2'b00);
            end
            if (done) bad_done = 1;
            wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_data  = $urandom;
            fire = wr_valid && wr_ready;
            if (fire) begin
                ref_mem[ea] = wr_data;
                pa = ea; pd = wr_data;
                ea = ea + 5'd1;
                sent++;
            end
            pf = fire;
            @(negedge clk);
            cyc++;
        end
        wr_valid = 1'b0;
        check({tag, "_beats"}, sent, len);
        check({tag, "_no_early_done"}, bad_done, 0);
        check({tag, "_last_pins"}, {ram_ena, ram_wena, ram_addr}, {2'b11, pa});
        check({tag, "_last_bus"}, ram_data, pd);
        check({tag, "_drain_done"}, done, 0);
        @(negedge clk);
        check({tag, "_done"}, {done, cmd_ready, ram_ena, ram_wena}, 4'b1100);
        @(negedge clk);
        check({tag, "_done_width"}, done, 0);
        for (int i = 0; i < len; i++)
            check({tag, "_mem"}, mem[5'(a + i)], ref_mem[5'(a + i)]);
    endtask

    // mode 0: rd_ready held high; 1: one cycle on, three off; 2: random.
    task automatic do_read(input logic [4:0] a, input int len, input int mode, input string tag);
        logic [31:0] expq[$];
        int cyc = 1;
        int got = 0;
        int issued = 0;
        int first_cyc = -1;
        int last_cyc = 0;
        int maxocc = 0;
        bit bad_done = 0;
        bit bad_wena = 0;
        for (int i = 0; i < len; i++) expq.push_back(ref_mem[5'(a + i)]);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = a; cmd_len = 6'(len);
        @(negedge clk);
        cmd_valid = 1'b0;
        while (got < len && cyc < 400) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (cyc % 4 == 0);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            if (ram_ena && ram_wena) bad_wena = 1;
            if (ram_ena && !ram_wena) begin
                check({tag, "_raddr"}, ram_addr, 5'(a + issued));
                issued++;
            end
            if (issued - got > maxocc) maxocc = issued - got;
            if (done) bad_done = 1;
            if (rd_valid && rd_ready) begin
                check({tag, "_data"}, rd_data, expq.pop_front());
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        rd_ready = 1'b0;
        check({tag, "_beats"}, got, len);
        check({tag, "_issued"}, issued, len);
        check({tag, "_occupancy_le2"}, maxocc <= 2, 1);
        check({tag, "_no_bus_write"}, bad_wena, 0);
        check({tag, "_no_early_done"}, bad_done, 0);
        if (mode == 0) begin
            check({tag, "_first_latency"}, first_cyc, 3);
            check({tag, "_back_to_back"}, last_cyc - first_cyc, len - 1);
        end
        check({tag, "_done"}, {done, cmd_ready, rd_valid}, 3'b110);
        @(negedge clk);
        check({tag, "_done_width"}, done, 0);
    endtask

    initial begin
        logic [31:0] d0, d1;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst = 1'b0;
        @(negedge clk);

        // Zero-length command: done next cycle, no RAM access.
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 5'd7; cmd_len = '0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("len0_done", {done, cmd_ready, ram_ena}, 3'b110);
        @(negedge clk);
        check("len0_done_width", {done, ram_ena}, 2'b00);

        do_write(5'd0, 32, 0, "wr_full");
        do_write(5'd3, 4, 0, "wr_a3");
        do_read(5'd3, 4, 0, "rd_a3");
        do_write(5'd30, 4, 1, "wr_wrap");
        do_read(5'd30, 4, 2, "rd_wrap");
        do_read(5'd0, 6, 1, "rd_bp");
        do_read(5'd17, 32, 2, "rd_full");

        // Reset during a write burst: third beat is registered but never committed.
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 5'd10; cmd_len = 6'd8;
        @(negedge clk);
        cmd_valid = 1'b0;
        d0 = $urandom; d1 = $urandom;
        wr_valid = 1'b1; wr_data = d0; @(negedge clk);
        wr_data = d1; @(negedge clk);
        wr_data = $urandom; @(negedge clk);
        wr_valid = 1'b0;
        ref_mem[10] = d0;
        ref_mem[11] = d1;
        check("midrst_pre_wena", ram_wena, 1);
        #2 rst = 1'b1;
        #1 reset_checks("midrst");
        @(negedge clk);
        check("midrst_no_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_after_done", done, 0);
        check("midrst_lost_word", mem[12], ref_mem[12]);
        do_read(5'd10, 8, 0, "rd_after_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ram_bus_master.md
# ram_bus_master

Bus initiator for the single-port 32x32 RAM that shares a bidirectional data bus. It turns burst read/write commands into RAM-side `ena`/`wena`/`addr` cycles, drives the shared `data` bus only while writing, and streams read data back through a ready/valid port. It sits between a client (CPU, DMA or test logic) and the RAM.

## Interface
Parameters:
- `AW`, 5: RAM address width (depth 2^AW).
- `DW`, 32: data width.
- `LENW`, 6: burst length field width; the maximum length is 2^AW = 32.

Ports:
- `clk` in 1: clock. All logic is on the rising edge.
- `rst` in 1: reset. Asynchronous and active-high.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_wr` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in AW: start address.
- `cmd_len` in LENW: beat count, 0..32.
- `wr_valid` in 1 / `wr_ready` out 1 / `wr_data` in DW: write-data stream.
- `rd_valid` out 1 / `rd_ready` in 1 / `rd_data` out DW: read-data stream.
- `done` out 1: one-cycle pulse when a burst completes.
- `ram_ena` out 1: RAM enable.
- `ram_wena` out 1: RAM write enable (1 = write, 0 = read).
- `ram_addr` out AW: RAM address.
- `ram_data` inout DW: shared data bus. Driven only when `ram_ena && ram_wena`, otherwise high-Z.

## Operation
- The FSM has four states: IDLE, WRITE, WDRAIN, READ.
- `cmd_ready` = (state == IDLE).
- A command is accepted on an edge where `cmd_valid && cmd_ready`. At acceptance `cur_addr` <= `cmd_addr` and `remain` <= `cmd_len`.
  - `cmd_len` == 0: next state is IDLE and `done` pulses in the following cycle. No RAM access occurs.
  - `cmd_wr` = 1: go to WRITE. `cmd_wr` = 0: go to READ.
- WRITE:
  - `wr_ready` = 1 while `remain` > 0.
  - On each accepted beat, register `ram_ena`=1, `ram_wena`=1, `ram_addr`=`cur_addr`, output data = `wr_data`. Then `cur_addr`++ and `remain`--.
  - If no beat is accepted, register `ram_ena`=0.
  - The last beat moves the FSM to WDRAIN.
- WDRAIN: lasts one cycle. The RAM commits the last word at the end of this cycle; then `ram_ena` <= 0, `done` <= 1 and state <= IDLE.
- READ:
  - Issue a RAM read (register `ram_ena`=1, `ram_wena`=0, `ram_addr`=`cur_addr`; then `cur_addr`++, `remain`--) when `remain` > 0 and (fifo_count + inflight − pop) < 2.
  - In the cycle after an issue, `ram_data` is sampled at the edge and pushed into a 2-entry FIFO.
  - `rd_valid` = FIFO not empty. `rd_data` = FIFO head. Pop on `rd_valid && rd_ready`.
  - When `remain` == 0, inflight == 0, and the FIFO empties by that pop: `done` <= 1 and state <= IDLE.
- Address arithmetic is modulo 2^AW: address 31 increments to 0.
- Write beat data is never modified. Read data is returned in issue order.

## Timing
- Reset values: state IDLE, `cmd_ready` 1, `wr_ready` 0, `rd_valid` 0, `rd_data` 0, `done` 0, `ram_ena` 0, `ram_wena` 0, `ram_addr` 0, FIFO empty, `ram_data` released to Z immediately (asynchronous).
- Reset mid-burst:
  - The burst is abandoned and no `done` pulses.
  - A RAM write already registered but not yet clocked is lost.
- Write latency: beat accepted at edge E → RAM pins valid during cycle E..E+1 → RAM writes at E+1.
  - After the last beat at E, `done` and `cmd_ready` are high in the cycle after E+1.
  - Peak rate is 1 beat/cycle. `wr_valid` gaps insert `ram_ena`=0 cycles.
- Read latency: issue at edge E → RAM pins valid during E..E+1 → captured at E+1 → `rd_valid` high after E+1.
  - With `rd_ready` held high, sustained rate is 1 beat/cycle.
  - With `rd_ready` low, at most 2 words are buffered and issue stalls.
- Bus turnaround:
  - The data-bus output enable is the same register bit as `ram_ena && ram_wena`, so drive and release happen on the same edge as `ram_wena`.
  - The block never drives `ram_data` during a read cycle.
- `done` is exactly one cycle wide and coincides with the first cycle `cmd_ready` = 1.

## Structure
- Package `ram_bus_pkg` holds:
  - constants AW, DW, LENW;
  - the FSM state enum (IDLE, WRITE, WDRAIN, READ).
- Sub-module `rd_fifo2`: 2-entry synchronous FIFO with count output and asynchronous reset. It is instantiated once for the read buffer.
- The top level holds the FSM, the `cur_addr`/`remain` counters, the RAM-pin registers and the tristate assign.

## Test plan
- Write burst, addr 3, len 4, data A0..A3 with `wr_valid` held high → RAM words 3..6 = A0..A3; `ram_data` is Z outside the 4 write cycles; `done` is 1 cycle, 2 cycles after the last beat.
- Read burst, addr 3, len 4, `rd_ready`=1 → `rd_data` A0..A3 on consecutive cycles, first word 2 cycles after command accept; `done` pulses once.
- Wrap: write addr 30, len 4 → words 30, 31, 0, 1 written. A read of the same range returns the data in order.
- Backpressure: read len 6 with `rd_ready` toggling 1 cycle on / 3 cycles off → no data lost or duplicated; inflight + FIFO ≤ 2; no bus contention (the RAM drives only while `ram_wena`=0).
- Edge cases:
  - `cmd_len`=0 → `done` next cycle with no `ram_ena`.
  - `rst` asserted mid-write burst → all outputs immediately at reset values, `ram_data` Z, no `done`.
  - A new command after reset executes normally.
